// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (instruction fetch, load/store) for a single-port word memory.
// Data wins by default; a bounded streak counter forces a fetch grant so fetch never starves.
module mem_port_arbiter #(
  parameter int AW          = 9,
  parameter int DW          = 32,
  parameter int MAX_DSTREAK = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [31:0]   if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [31:0]   d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          d_err,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, DATA, INSTR, STARVE} state_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_DSTREAK);

  state_t        state_reg, state_next;
  logic [3:0]    streak_reg, streak_next;
  logic          if_rvalid_reg, d_rvalid_reg, d_err_reg;
  logic [DW-1:0] if_rdata_reg, d_rdata_reg;

  // Index 0 is the fetch port, index 1 the data port.
  logic [31:0] req_addr [2];
  logic [1:0]  in_range;

  assign req_addr[0] = if_addr;
  assign req_addr[1] = d_addr;

  for (genvar gi = 0; gi < 2; gi++) begin : g_range
    assign in_range[gi] = (req_addr[gi][31:AW] == '0);
  end

  always_comb begin
    if_gnt      = 1'b0;
    d_gnt       = 1'b0;
    mem_addr    = if_addr[AW-1:0];
    mem_we      = 1'b0;
    mem_wdata   = d_wdata;
    streak_next = streak_reg;
    state_next  = IDLE;

    // Grants are suppressed while reset is held so no write can slip through.
    if (rst) begin
      if (d_req && !(state_reg == STARVE && if_req)) d_gnt = 1'b1;
      else if (if_req)                               if_gnt = 1'b1;
    end

    if (d_gnt) begin
      mem_addr = d_addr[AW-1:0];
      mem_we   = d_we & in_range[1];
    end

    if (if_gnt || !if_req)
      streak_next = '0;
    else if (d_gnt && streak_reg < STREAK_MAX)
      streak_next = streak_reg + 4'd1;

    if (d_gnt)
      state_next = (if_req && streak_next == STREAK_MAX) ? STARVE : DATA;
    else if (if_gnt)
      state_next = INSTR;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      streak_reg    <= '0;
      if_rvalid_reg <= 1'b0;
      d_rvalid_reg  <= 1'b0;
      d_err_reg     <= 1'b0;
      if_rdata_reg  <= '0;
      d_rdata_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      streak_reg    <= streak_next;
      if_rvalid_reg <= if_gnt;
      d_rvalid_reg  <= d_gnt & ~d_we;
      d_err_reg     <= d_gnt & ~in_range[1];
      // Out-of-range reads return zero rather than aliased memory contents.
      if (if_gnt)
        if_rdata_reg <= in_range[0] ? mem_rdata : '0;
      if (d_gnt && !d_we)
        d_rdata_reg <= in_range[1] ? mem_rdata : '0;
    end
  end

  assign if_rvalid = if_rvalid_reg;
  assign if_rdata  = if_rdata_reg;
  assign d_rvalid  = d_rvalid_reg;
  assign d_rdata   = d_rdata_reg;
  assign d_err     = d_err_reg;

endmodule
